// File: rtl/issue_stage_if.sv
// Instruction-memory fetch port between the issue stage (master) and the
// instruction memory (slave): one request outstanding, response strobed by imem_valid.
interface issue_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/issue_stage.sv
// CPU front end: fetch, IF/ID register with a one-entry skid buffer, hazard
// stall on the register-file pause code, branch flush and issue into execute.
module issue_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  issue_stage_if.master imem,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic [1:0]    pause,
  output logic [4:0]    read_addr1,
  output logic [4:0]    read_addr2,
  output logic [4:0]    collision_addr,
  output logic          ex_valid,
  output logic [31:0]   ex_instr,
  output logic [31:0]   ex_pc
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    PARK  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_instr_q, ex_instr_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic        issue;
  logic        slot_free;
  logic        req;

  // Register written by the instruction, 0 when it writes none (or only $0 by jr).
  function automatic logic [4:0] dest_reg(input logic [31:0] instr);
    logic [5:0] op;
    op       = instr[31:26];
    dest_reg = 5'd0;
    if (op == 6'h00) begin
      if (instr[5:0] != 6'h08)
        dest_reg = instr[15:11];
    end else if (op == 6'h03) begin
      dest_reg = 5'd31;
    end else if ((op >= 6'h08 && op <= 6'h0F) || op == 6'h23) begin
      dest_reg = instr[20:16];
    end
  endfunction

  assign issue     = id_valid_q && (pause == 2'b00) && !branch_taken;
  assign slot_free = !id_valid_q || issue;
  assign pc_plus4  = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    req          = 1'b0;

    if (issue)
      id_valid_d = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end

      FETCH: begin
        req = 1'b1;
        if (branch_taken) begin
          pc_d       = branch_target;
          id_valid_d = 1'b0;
          state_d    = imem.imem_valid ? FETCH : FLUSH;
        end else if (imem.imem_valid) begin
          pc_d = pc_plus4;
          if (slot_free) begin
            id_valid_d = 1'b1;
            id_instr_d = imem.imem_rdata;
            id_pc_d    = pc_q;
          end else begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem.imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = PARK;
          end
        end
      end

      PARK: begin
        if (branch_taken) begin
          skid_valid_d = 1'b0;
          id_valid_d   = 1'b0;
          pc_d         = branch_target;
          state_d      = FETCH;
        end else if (slot_free && skid_valid_q) begin
          id_valid_d   = 1'b1;
          id_instr_d   = skid_instr_q;
          id_pc_d      = skid_pc_q;
          skid_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end

      FLUSH: begin
        // The stale response of the abandoned path must drain before refetching.
        if (branch_taken) begin
          pc_d       = branch_target;
          id_valid_d = 1'b0;
        end
        if (imem.imem_valid)
          state_d = FETCH;
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    ex_valid_d = issue;
    ex_instr_d = issue ? id_instr_q : ex_instr_q;
    ex_pc_d    = issue ? id_pc_q    : ex_pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'd0;
      id_pc_q      <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
      ex_valid_q   <= 1'b0;
      ex_instr_q   <= 32'd0;
      ex_pc_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      ex_valid_q   <= ex_valid_d;
      ex_instr_q   <= ex_instr_d;
      ex_pc_q      <= ex_pc_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  assign read_addr1     = id_valid_q ? id_instr_q[25:21] : 5'd0;
  assign read_addr2     = id_valid_q ? id_instr_q[20:16] : 5'd0;
  assign collision_addr = issue ? dest_reg(id_instr_q) : 5'd0;

  assign ex_valid = ex_valid_q;
  assign ex_instr = ex_instr_q;
  assign ex_pc    = ex_pc_q;

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: directed scenarios plus a randomized run against a
// program-order reference (expected PC stream, memory contents, destination rules).
module tb_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        br;
  logic [31:0] tgt;
  logic [1:0]  pz;
  logic [4:0]  ra1, ra2, coll;
  logic        ex_valid_w;
  logic [31:0] ex_instr_w, ex_pc_w;
  logic [4:0]  d1_ra1, d1_ra2, d1_coll;
  logic        d1_exv;
  logic [31:0] d1_exi, d1_exp;

  int n_chk = 0;
  int n_err = 0;

  issue_stage_if m0 ();
  issue_stage_if m1 ();

  issue_stage dut0 (
    .clk(clk), .rst(rst), .imem(m0),
    .branch_taken(br), .branch_target(tgt), .pause(pz),
    .read_addr1(ra1), .read_addr2(ra2), .collision_addr(coll),
    .ex_valid(ex_valid_w), .ex_instr(ex_instr_w), .ex_pc(ex_pc_w)
  );

  issue_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .imem(m1),
    .branch_taken(1'b0), .branch_target(32'd0), .pause(2'b00),
    .read_addr1(d1_ra1), .read_addr2(d1_ra2), .collision_addr(d1_coll),
    .ex_valid(d1_exv), .ex_instr(d1_exi), .ex_pc(d1_exp)
  );

  // Zero-wait memory for the wrap-around instance.
  assign m1.imem_valid = m1.imem_req;
  assign m1.imem_rdata = 32'h2001_0005;

  always #5 clk = ~clk;

  logic        rst_nx, br_nx;
  logic [31:0] tgt_nx;
  logic [1:0]  pz_nx;
  logic        ovr_en;
  logic [31:0] ovr_word;
  int          lat_fix;
  logic        busy;
  int          cnt;
  logic [31:0] addr_l;
  logic        req_s;
  logic [31:0] addr_s;
  logic [4:0]  coll_s, ra1_s, ra2_s;
  logic        m1_req_s;
  logic [31:0] m1_addr_s;
  logic        sb_on;
  logic [31:0] exp_pc;
  int          idle;
  int          n_iss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    logic [31:0] h;
    if (ovr_en) return ovr_word;
    h = a * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    case (h[2:0])
      3'd0: return {6'h00, h[25:6], 6'h20};
      3'd1: return {6'h00, h[25:6], 6'h08};
      3'd2: return {6'h03, h[25:0]};
      3'd3: return {6'h08, h[25:0]};
      3'd4: return {6'h0F, h[25:0]};
      3'd5: return {6'h23, h[25:0]};
      3'd6: return {6'h2B, h[25:0]};
      default: return {6'h04, h[25:0]};
    endcase
  endfunction

  function automatic logic [4:0] dest_ref(input logic [31:0] w);
    int op;
    op = int'(w[31:26]);
    if (op == 0)  return (w[5:0] == 6'h08) ? 5'd0 : w[15:11];
    if (op == 3)  return 5'd31;
    if (op == 35) return w[20:16];
    if (op >= 8 && op <= 15) return w[20:16];
    return 5'd0;
  endfunction

  // One clock: drive inputs and the memory at negedge, sample after the edge.
  task automatic step();
    @(negedge clk);
    rst = rst_nx; pz = pz_nx; br = br_nx; tgt = tgt_nx;
    #1;
    if (!rst) begin
      busy = 1'b0;
      m0.imem_valid = 1'b0;
      m0.imem_rdata = $urandom;
    end else begin
      if (!busy && m0.imem_req) begin
        busy = 1'b1;
        addr_l = m0.imem_addr;
        cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      end else if (busy && m0.imem_req) begin
        chk("addr_stable", m0.imem_addr, addr_l);
      end
      if (busy && cnt == 0) begin
        m0.imem_valid = 1'b1;
        m0.imem_rdata = mem_fn(addr_l);
        busy = 1'b0;
      end else begin
        m0.imem_valid = 1'b0;
        m0.imem_rdata = $urandom;
        if (busy) cnt--;
      end
    end
    #1;
    req_s = m0.imem_req; addr_s = m0.imem_addr;
    coll_s = coll; ra1_s = ra1; ra2_s = ra2;
    m1_req_s = m1.imem_req; m1_addr_s = m1.imem_addr;
    @(posedge clk);
    #1;
    if (sb_on) begin
      if (ex_valid_w) begin
        chk("sb_ex_pc", ex_pc_w, exp_pc);
        chk("sb_ex_instr", ex_instr_w, mem_fn(ex_pc_w));
        chk("sb_coll_issue", {27'd0, coll_s}, {27'd0, dest_ref(ex_instr_w)});
        chk("sb_ra1_issue", {27'd0, ra1_s}, {27'd0, ex_instr_w[25:21]});
        chk("sb_ra2_issue", {27'd0, ra2_s}, {27'd0, ex_instr_w[20:16]});
        exp_pc = exp_pc + 32'd4;
        idle = 0;
        n_iss++;
      end else begin
        chk("sb_coll_idle", {27'd0, coll_s}, 32'd0);
        idle++;
        if (idle > 200) begin
          chk("sb_issue_timeout", idle, 0);
          idle = 0;
        end
      end
      if (br) exp_pc = tgt;
    end
  endtask

  task automatic restart(input logic [31:0] word, input int lat);
    ovr_en = 1'b1; ovr_word = word; lat_fix = lat;
    pz_nx = 2'b00; br_nx = 1'b0; tgt_nx = 32'd0;
    rst_nx = 1'b0; step();
    rst_nx = 1'b1; step();
  endtask

  logic [31:0] dec_w [6];
  logic [4:0]  dec_e [6];
  logic        got;
  logic        old_seen;

  initial begin
    rst = 1'b0; br = 1'b0; tgt = 32'd0; pz = 2'b00;
    m0.imem_valid = 1'b0; m0.imem_rdata = 32'd0;
    rst_nx = 1'b0; br_nx = 1'b0; tgt_nx = 32'd0; pz_nx = 2'b00;
    ovr_en = 1'b1; ovr_word = 32'h2001_0005; lat_fix = 0;
    busy = 1'b0; cnt = 0; addr_l = 0; sb_on = 1'b0; exp_pc = 0; idle = 0; n_iss = 0;

    // Reset values, then zero-wait fetch of addi $1 from pc 0
    step(); step();
    chk("rst_req", {31'd0, req_s}, 32'd0);
    chk("rst_addr", addr_s, 32'd0);
    chk("rst_ra1", {27'd0, ra1_s}, 32'd0);
    chk("rst_ra2", {27'd0, ra2_s}, 32'd0);
    chk("rst_coll", {27'd0, coll_s}, 32'd0);
    chk("rst_exv", {31'd0, ex_valid_w}, 32'd0);
    chk("rst_exi", ex_instr_w, 32'd0);
    chk("rst_exp", ex_pc_w, 32'd0);
    chk("rst_d1_addr", m1_addr_s, 32'hFFFF_FFFC);
    rst_nx = 1'b1; step();
    chk("boot_req", {31'd0, req_s}, 32'd0);
    step();
    chk("f1_req", {31'd0, req_s}, 32'd1);
    chk("f1_addr", addr_s, 32'd0);
    chk("d1_f1_addr", m1_addr_s, 32'hFFFF_FFFC);
    step();
    chk("f2_addr", addr_s, 32'd4);
    chk("f2_coll", {27'd0, coll_s}, 32'd1);
    chk("f2_exv", {31'd0, ex_valid_w}, 32'd1);
    chk("f2_exp", ex_pc_w, 32'd0);
    chk("f2_exi", ex_instr_w, 32'h2001_0005);
    chk("d1_wrap_addr", m1_addr_s, 32'd0);
    chk("d1_wrap_req", {31'd0, m1_req_s}, 32'd1);
    step();
    chk("f3_addr", addr_s, 32'd8);

    // Pause on add $3,$1,$2 for three cycles, then release
    restart(32'h0022_1820, 0);
    step();
    pz_nx = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ra1", {27'd0, ra1_s}, 32'd1);
      chk("stall_ra2", {27'd0, ra2_s}, 32'd2);
      chk("stall_coll", {27'd0, coll_s}, 32'd0);
      chk("stall_exv", {31'd0, ex_valid_w}, 32'd0);
      if (i > 0) chk("park_req", {31'd0, req_s}, 32'd0);
    end
    pz_nx = 2'b00; step();
    chk("rel_coll", {27'd0, coll_s}, 32'd3);
    chk("rel_exv", {31'd0, ex_valid_w}, 32'd1);
    chk("rel_exp", ex_pc_w, 32'd0);
    step();
    chk("skid_coll", {27'd0, coll_s}, 32'd3);
    chk("skid_exp", ex_pc_w, 32'd4);
    chk("skid_addr", addr_s, 32'd8);
    pz_nx = 2'b01; step();
    // Now parked with a non-reset ID/EX; reset asynchronously mid-cycle
    @(negedge clk);
    #2;
    chk("prepark_req", {31'd0, m0.imem_req}, 32'd0);
    chk("prepark_ra1", {27'd0, ra1}, 32'd1);
    chk("prepark_exp", ex_pc_w, 32'd4);
    rst = 1'b0;
    #1;
    chk("arst_req", {31'd0, m0.imem_req}, 32'd0);
    chk("arst_addr", m0.imem_addr, 32'd0);
    chk("arst_ra1", {27'd0, ra1}, 32'd0);
    chk("arst_ra2", {27'd0, ra2}, 32'd0);
    chk("arst_coll", {27'd0, coll}, 32'd0);
    chk("arst_exv", {31'd0, ex_valid_w}, 32'd0);
    chk("arst_exi", ex_instr_w, 32'd0);
    chk("arst_exp", ex_pc_w, 32'd0);
    rst_nx = 1'b0; pz_nx = 2'b00;

    // Latency 3, branch in the second wait cycle
    restart(32'h2001_0005, 3);
    old_seen = 1'b0;
    step();
    old_seen = old_seen | ex_valid_w;
    br_nx = 1'b1; tgt_nx = 32'h100; step();
    old_seen = old_seen | ex_valid_w;
    br_nx = 1'b0; step();
    chk("flush_req", {31'd0, req_s}, 32'd0);
    old_seen = old_seen | ex_valid_w;
    step();
    chk("flush_drain_req", {31'd0, req_s}, 32'd0);
    old_seen = old_seen | ex_valid_w;
    step();
    chk("redir_req", {31'd0, req_s}, 32'd1);
    chk("redir_addr", addr_s, 32'h100);
    old_seen = old_seen | ex_valid_w;
    chk("old_path_issue", {31'd0, old_seen}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if (ex_valid_w) begin
        got = 1'b1;
        chk("redir_exp", ex_pc_w, 32'h100);
      end
    end
    chk("redir_issued", {31'd0, got}, 32'd1);

    // Branch against a valid, unpaused ID entry
    restart(32'h2001_0005, 0);
    step();
    br_nx = 1'b1; tgt_nx = 32'h200; step();
    chk("bid_coll", {27'd0, coll_s}, 32'd0);
    chk("bid_exv", {31'd0, ex_valid_w}, 32'd0);
    br_nx = 1'b0; step();
    chk("bid_ra1_clr", {27'd0, ra1_s}, 32'd0);
    chk("bid_addr", addr_s, 32'h200);
    chk("bid_exv2", {31'd0, ex_valid_w}, 32'd0);
    step();
    chk("bid_exp", ex_pc_w, 32'h200);

    // Destination decode sweep
    dec_w[0] = 32'h0C00_0010; dec_e[0] = 5'd31;
    dec_w[1] = 32'h03E0_0008; dec_e[1] = 5'd0;
    dec_w[2] = 32'hAC22_0004; dec_e[2] = 5'd0;
    dec_w[3] = 32'h8C43_0000; dec_e[3] = 5'd3;
    dec_w[4] = 32'h3C05_0001; dec_e[4] = 5'd5;
    dec_w[5] = 32'h0085_3820; dec_e[5] = 5'd7;
    for (int k = 0; k < 6; k++) begin
      restart(dec_w[k], 0);
      step(); step();
      chk($sformatf("decode_%0d", k), {27'd0, coll_s}, {27'd0, dec_e[k]});
    end

    // Randomized run against the program-order reference
    ovr_en = 1'b0; lat_fix = -1;
    pz_nx = 2'b00; br_nx = 1'b0;
    rst_nx = 1'b0; step();
    rst_nx = 1'b1; step();
    exp_pc = 32'd0; idle = 0; n_iss = 0; sb_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      pz_nx  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      br_nx  = ($urandom_range(0, 15) == 0);
      tgt_nx = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      step();
    end
    sb_on = 1'b0;
    chk("rand_progress", {31'd0, (n_iss > 500)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
